// File: rtl/hs_pkg.sv
// Shared defaults for the handshake buffer and its protocol checker.
package hs_pkg;

  localparam int unsigned HS_DATA_W = 32;
  localparam int unsigned HS_DEPTH  = 4;
  localparam int unsigned HS_CNT_W  = $clog2(HS_DEPTH + 1);

endpackage

// File: rtl/hs_proto_chk.sv
// Flags an upstream source that withdraws or alters a beat while it is stalled.
module hs_proto_chk
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = HS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              err
);

  logic              stall_q, stall_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  // A stall obliges the source to present the same beat on the next cycle.
  always_comb begin
    stall_d = valid && !ready;
    data_d  = data;
    err_d   = err_q;
    if (stall_q && (!valid || (data != data_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/hs_buffer.sv
// Valid/ready FIFO buffer with beat counters and a sticky upstream protocol flag.
module hs_buffer
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = HS_DATA_W,
  parameter int unsigned DEPTH  = HS_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       proto_err,
  output logic [31:0]                beats_in,
  output logic [31:0]                beats_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       bin_q, bin_d;
  logic [31:0]       bout_q, bout_d;
  logic              push, pop;

  // Handshake flags depend only on registered occupancy.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    bin_d   = bin_q;
    bout_d  = bout_q;
    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
      bin_d  = bin_q + 32'd1;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
      bout_d = bout_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      bin_q   <= '0;
      bout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      bin_q   <= bin_d;
      bout_q  <= bout_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  hs_proto_chk #(
    .DATA_W (DATA_W)
  ) u_proto_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (in_valid),
    .ready (in_ready),
    .data  (in_data),
    .err   (proto_err)
  );

  assign count     = count_q;
  assign beats_in  = bin_q;
  assign beats_out = bout_q;

endmodule

// File: tb/tb_hs_buffer.sv
// Directed and randomized checks of hs_buffer against a queue scoreboard.
module tb_hs_buffer;
  import hs_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic [HS_CNT_W-1:0] count;
  logic                proto_err;
  logic [31:0]         beats_in;
  logic [31:0]         beats_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        push_s = 1'b0;
  logic        pop_s  = 1'b0;

  hs_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .proto_err (proto_err),
    .beats_in  (beats_in),
    .beats_out (beats_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score the handshakes of the upcoming edge, then advance one cycle.
  task automatic tick();
    #1;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      pop_s  = out_valid && out_ready;
      push_s = in_valid && in_ready;
      if (pop_s) begin
        if (exp_q.size() == 0) chk("sb_unexpected_beat", 32'd1, 32'd0);
        else chk("sb_data", out_data, exp_q.pop_front());
      end
      if (push_s) exp_q.push_back(in_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] bi0, bo0;
  int sent, got, cyc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_beats_in", beats_in, 32'd0);
    chk("rst_beats_out", beats_out, 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    // Single beat: stored only during the push cycle, visible one cycle later.
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    chk("single_no_bypass", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", out_data, 32'hA5A5_0001);
    chk("single_count1", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_count0", 32'(count), 32'd0);
    chk("single_empty", 32'(out_valid), 32'd0);

    // Fill to DEPTH; a fifth beat waits, held stable, until space opens.
    fill(32'h10, 4);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 32'h14;
    tick();
    chk("fill_5th_count", 32'(count), 32'd4);
    chk("fill_5th_beats_in", beats_in, 32'd5);
    out_ready = 1'b1;
    tick();
    chk("full_pop_no_write", 32'(count), 32'd3);
    tick();
    chk("fifth_accepted", 32'(beats_in), 32'd6);
    drain();
    chk("fill_drained", 32'(count), 32'd0);
    chk("fill_proto_ok", 32'(proto_err), 32'd0);
    chk("fill_sb_empty", 32'(exp_q.size()), 32'd0);

    // Concurrent push and pop at occupancy two.
    fill(32'h200, 2);
    bi0 = beats_in; bo0 = beats_out;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h100 + 32'(i);
      tick();
      chk("sim_count", 32'(count), 32'd2);
    end
    chk("sim_beats_in", beats_in - bi0, 32'd8);
    chk("sim_beats_out", beats_out - bo0, 32'd8);
    drain();
    chk("sim_sb_empty", 32'(exp_q.size()), 32'd0);

    // Withdrawn beat while stalled.
    do_reset();
    fill(32'h30, 4);
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    chk("drop_no_err_yet", 32'(proto_err), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("drop_err", 32'(proto_err), 32'd1);
    tick(); tick();
    chk("drop_err_sticky", 32'(proto_err), 32'd1);

    // Altered beat while stalled; flow continues despite the flag.
    do_reset();
    chk("rst_clears_err", 32'(proto_err), 32'd0);
    fill(32'h40, 4);
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_data = 32'h56;
    tick();
    in_valid = 1'b0;
    chk("change_err", 32'(proto_err), 32'd1);
    drain();
    chk("err_no_block", 32'(count), 32'd0);
    chk("err_beats_out", beats_out, 32'd4);
    chk("change_err_sticky", 32'(proto_err), 32'd1);

    // Reset with three beats buffered.
    do_reset();
    fill(32'h60, 3);
    chk("mid_count3", 32'(count), 32'd3);
    do_reset();
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_beats_in", beats_in, 32'd0);
    chk("mid_beats_out", beats_out, 32'd0);
    chk("mid_proto_err", 32'(proto_err), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("mid_no_beat", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Random stalls on both sides; source holds its beat while stalled.
    do_reset();
    sent = 0; got = 0; cyc = 0;
    push_s = 1'b0; in_valid = 1'b0;
    while ((got < 10000) && (cyc < 80000)) begin
      if (!(in_valid && !push_s)) begin
        if ((sent < 10000) && ($urandom_range(0, 1) == 1)) begin
          in_valid = 1'b1; in_data = $urandom;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      if (push_s) sent++;
      if (pop_s) got++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stress_within_budget", 32'(cyc < 80000), 32'd1);
    chk("stress_beats_in", beats_in, 32'd10000);
    chk("stress_beats_out", beats_out, 32'd10000);
    chk("stress_proto_err", 32'(proto_err), 32'd0);
    chk("stress_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("stress_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
